spi_ram_slave_p: RTL



---
 rtl/spi_ram_slave_p_if.sv | 10 +
 rtl/spi_ram_slave_p.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_slave_p_if.sv
// SPI pin bundle between a host (master) and the RAM-backed SPI slave.
// The slave modport is the view used by spi_ram_slave_p.
interface spi_ram_slave_p_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output MOSI, input MISO);
  modport slave  (input SS_n, input MOSI, output MISO);
endinterface

// File: rtl/spi_ram_slave_p.sv
// Parametrised SPI slave with single-port RAM, address frames and data frames.
// Define SPI_BURST_EN for multi-word bursts with pointer auto-increment.
module spi_ram_slave_p #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_slave_p_if.slave spi
);
  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW) + 1;
  localparam logic [CW-1:0]         ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef SPI_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    RD_ADDR = 3'd4,
    RD_WAIT = 3'd5,
    RD_DATA = 3'd6
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CW-1:0]           cnt_r;
  logic [SW-1:0]           shift_r;
  logic [ADDR_WIDTH-1:0]   wr_ptr_r;
  logic [ADDR_WIDTH-1:0]   rd_ptr_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    miso_r;
  logic                    hold_r;
  logic                    cmd_hi_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  logic                    ss_s;
  logic                    mosi_s;
  logic [DATA_WIDTH-1:0]   wr_word_s;
  logic [ADDR_WIDTH-1:0]   addr_word_s;
  logic [ADDR_WIDTH-1:0]   wr_inc_s;
  logic [ADDR_WIDTH-1:0]   rd_inc_s;
  logic [ADDR_WIDTH-1:0]   rd_sel_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic                    wr_en_s;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] ptr);
    return ({1'b0, ptr} < DEPTH_L);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? PTR_ZERO : ptr + PTR_ONE;
  endfunction

  assign ss_s     = spi.SS_n;
  assign mosi_s   = spi.MOSI;
  assign spi.MISO = miso_r;

  // Word assembly, pointer wrap, RAM read select and write enable
  always_comb begin
    wr_word_s   = {shift_r[DATA_WIDTH-2:0], mosi_s};
    addr_word_s = {shift_r[ADDR_WIDTH-2:0], mosi_s};
    wr_inc_s    = ptr_inc(wr_ptr_r);
    rd_inc_s    = ptr_inc(rd_ptr_r);
    rd_sel_s    = rd_inc_s;
    rd_word_s   = {DATA_WIDTH{1'b0}};
    wr_en_s     = 1'b0;
    if (state_r == RD_WAIT) begin
      rd_sel_s = rd_ptr_r;
    end else begin
      rd_sel_s = rd_inc_s;
    end
    // Out-of-range locations read as zero
    if (in_range(rd_sel_s)) begin
      rd_word_s = mem_r[rd_sel_s];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
    if (!ss_s && (state_r == WR_DATA) && !hold_r && (cnt_r == DATA_LAST) && in_range(wr_ptr_r)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; SS_n high aborts from any state
  always_comb begin
    state_nxt_s = state_r;
    if (ss_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = CMD;
        CMD: begin
          case ({cmd_hi_r, mosi_s})
            2'b00:   state_nxt_s = WR_ADDR;
            2'b01:   state_nxt_s = WR_DATA;
            2'b10:   state_nxt_s = RD_ADDR;
            2'b11:   state_nxt_s = RD_WAIT;
            default: state_nxt_s = IDLE;
          endcase
        end
        RD_WAIT: state_nxt_s = RD_DATA;
        default: state_nxt_s = state_r;
      endcase
    end
  end

  // Serial datapath: bit counter, shifter, pointers, read buffer and MISO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      shift_r   <= {SW{1'b0}};
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      rd_data_r <= {DATA_WIDTH{1'b0}};
      miso_r    <= 1'b0;
      hold_r    <= 1'b0;
      cmd_hi_r  <= 1'b0;
    end else if (ss_s) begin
      cnt_r   <= CNT_ZERO;
      shift_r <= {SW{1'b0}};
      miso_r  <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cmd_hi_r <= mosi_s;
          cnt_r    <= CNT_ZERO;
          hold_r   <= 1'b0;
          miso_r   <= 1'b0;
        end
        CMD: begin
          cnt_r  <= CNT_ZERO;
          miso_r <= 1'b0;
        end
        WR_ADDR, RD_ADDR: begin
          miso_r <= 1'b0;
          if (!hold_r) begin
            shift_r <= {shift_r[SW-2:0], mosi_s};
            if (cnt_r == ADDR_LAST) begin
              cnt_r  <= CNT_ZERO;
              hold_r <= 1'b1;
              if (state_r == WR_ADDR) begin
                wr_ptr_r <= addr_word_s;
              end else begin
                rd_ptr_r <= addr_word_s;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        WR_DATA: begin
          miso_r <= 1'b0;
          if (!hold_r) begin
            shift_r <= {shift_r[SW-2:0], mosi_s};
            if (cnt_r == DATA_LAST) begin
              cnt_r <= CNT_ZERO;
              if (BURST_EN) begin
                wr_ptr_r <= wr_inc_s;
              end else begin
                hold_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        RD_WAIT: begin
          rd_data_r <= rd_word_s;
          cnt_r     <= CNT_ZERO;
          miso_r    <= 1'b0;
        end
        RD_DATA: begin
          if (hold_r) begin
            miso_r <= 1'b0;
          end else begin
            if (cnt_r == CNT_ZERO) begin
              miso_r  <= rd_data_r[DATA_WIDTH-1];
              shift_r <= SW'({rd_data_r[DATA_WIDTH-2:0], 1'b0});
            end else begin
              miso_r  <= shift_r[DATA_WIDTH-1];
              shift_r <= {shift_r[SW-2:0], 1'b0};
            end
            // Prefetch the following word once the current one is in the shifter
            if (BURST_EN && (cnt_r == CNT_ONE)) begin
              rd_data_r <= rd_word_s;
            end
            if (cnt_r == DATA_LAST) begin
              cnt_r <= CNT_ZERO;
              if (BURST_EN) begin
                rd_ptr_r <= rd_inc_s;
              end else begin
                hold_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          cnt_r  <= CNT_ZERO;
          miso_r <= 1'b0;
          hold_r <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end
endmodule
